// File: rtl/hs_fifo_stage.sv
// hs_fifo_stage: elastic req/ack buffer stage in front of the arf graph input.
// Pulls words from an upstream producer (req_l/ack_l/din), keeps them in a
// depth-entry circular buffer and serves them downstream (req_r/ack_r/dout).
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   req_l     request to upstream producer (registered)
//   ack_l     one-cycle ack from producer, din valid in the same cycle
//   din       upstream data
//   req_r     request from downstream operator
//   ack_r     one-cycle ack pulse to downstream, never on two consecutive cycles
//   dout      downstream data, registered and held between transfers
//   level     current occupancy
//   overflow  sticky flag: a word arrived with no free entry
//
// Optional statistics (macro HS_FIFO_STATS_EN):
//   cnt_in    accepted writes (dropped words excluded)
//   cnt_out   completed reads
//   max_level high-water mark of level
module hs_fifo_stage #(
  parameter int data_width = 32,
  parameter int depth      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         req_l,
  input  logic                         ack_l,
  input  logic [data_width-1:0]        din,
  input  logic                         req_r,
  output logic                         ack_r,
  output logic [data_width-1:0]        dout,
  output logic [$clog2(depth+1)-1:0]   level,
  output logic                         overflow
`ifdef HS_FIFO_STATS_EN
  ,
  output logic [31:0]                  cnt_in,
  output logic [31:0]                  cnt_out,
  output logic [$clog2(depth+1)-1:0]   max_level
`endif
);

  localparam int LW = $clog2(depth + 1);
  localparam int PW = $clog2(depth);
  localparam logic [LW-1:0] DEPTH_L  = LW'(depth);
  localparam logic [PW-1:0] LAST_PTR = PW'(depth - 1);

  logic [data_width-1:0] mem [depth];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic                  rd;
  logic                  wr;
  logic [LW-1:0]         level_eff;
  logic [LW-1:0]         level_next;

  // The read is resolved first so that a write on the same edge sees the
  // entry freed by that read (write accepted even when full).
  always_comb begin
    rd         = req_r & ~ack_r & (level != '0);
    level_eff  = level - LW'(rd);
    wr         = ack_l & (level_eff < DEPTH_L);
    level_next = level_eff + LW'(wr);
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      req_l    <= 1'b0;
      ack_r    <= 1'b0;
      dout     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wptr <= (wptr == LAST_PTR) ? '0 : wptr + PW'(1);
      if (rd) begin
        rptr <= (rptr == LAST_PTR) ? '0 : rptr + PW'(1);
        dout <= mem[rptr];
      end
      ack_r <= rd;
      level <= level_next;
      req_l <= (level_next < DEPTH_L);
      if (ack_l & ~wr) overflow <= 1'b1;
    end
  end

`ifdef HS_FIFO_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_in    <= '0;
      cnt_out   <= '0;
      max_level <= '0;
    end else begin
      if (wr) cnt_in  <= cnt_in + 32'd1;
      if (rd) cnt_out <= cnt_out + 32'd1;
      if (level_next > max_level) max_level <= level_next;
    end
  end
`endif

endmodule

// File: tb/tb_hs_fifo_stage.sv
// Testbench for hs_fifo_stage: a depth-4 and a depth-3 instance, a directed
// vector table, hand-written reset sequences and randomized streams, all
// compared against a queue-style reference model of the buffer.
module tb_hs_fifo_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance a: depth 4
  logic        a_req_l, a_ack_l, a_req_r, a_ack_r, a_overflow;
  logic [31:0] a_din, a_dout;
  logic [2:0]  a_level;
  // instance b: depth 3
  logic        b_req_l, b_ack_l, b_req_r, b_ack_r, b_overflow;
  logic [31:0] b_din, b_dout;
  logic [1:0]  b_level;
`ifdef HS_FIFO_STATS_EN
  logic [31:0] a_cnt_in, a_cnt_out, b_cnt_in, b_cnt_out;
  logic [2:0]  a_max_level;
  logic [1:0]  b_max_level;
`endif

  hs_fifo_stage #(.data_width(32), .depth(4)) dut_a (
    .clk(clk), .rst(rst), .req_l(a_req_l), .ack_l(a_ack_l), .din(a_din),
    .req_r(a_req_r), .ack_r(a_ack_r), .dout(a_dout), .level(a_level),
    .overflow(a_overflow)
`ifdef HS_FIFO_STATS_EN
    , .cnt_in(a_cnt_in), .cnt_out(a_cnt_out), .max_level(a_max_level)
`endif
  );

  hs_fifo_stage #(.data_width(32), .depth(3)) dut_b (
    .clk(clk), .rst(rst), .req_l(b_req_l), .ack_l(b_ack_l), .din(b_din),
    .req_r(b_req_r), .ack_r(b_ack_r), .dout(b_dout), .level(b_level),
    .overflow(b_overflow)
`ifdef HS_FIFO_STATS_EN
    , .cnt_in(b_cnt_in), .cnt_out(b_cnt_out), .max_level(b_max_level)
`endif
  );

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // gathered views of both instances
  logic        in_ackl [2];
  logic [31:0] in_din  [2];
  logic        in_reqr [2];
  logic        o_reql  [2];
  logic        o_ack   [2];
  logic [31:0] o_dout  [2];
  logic [2:0]  o_lvl   [2];
  logic        o_ovf   [2];
  assign in_ackl[0] = a_ack_l;  assign in_ackl[1] = b_ack_l;
  assign in_din[0]  = a_din;    assign in_din[1]  = b_din;
  assign in_reqr[0] = a_req_r;  assign in_reqr[1] = b_req_r;
  assign o_reql[0]  = a_req_l;  assign o_reql[1]  = b_req_l;
  assign o_ack[0]   = a_ack_r;  assign o_ack[1]   = b_ack_r;
  assign o_dout[0]  = a_dout;   assign o_dout[1]  = b_dout;
  assign o_lvl[0]   = a_level;  assign o_lvl[1]   = {1'b0, b_level};
  assign o_ovf[0]   = a_overflow; assign o_ovf[1] = b_overflow;

  // Reference model: an ordered list of stored words (front = oldest).
  int          dep [2] = '{4, 3};
  logic [31:0] mq [2][8];
  int          mcnt [2] = '{0, 0};
  logic        mreq [2] = '{1'b0, 1'b0};
  logic        mack [2] = '{1'b0, 1'b0};
  logic [31:0] mdout [2] = '{32'h0, 32'h0};
  logic        movf [2] = '{1'b0, 1'b0};
  int          mcin [2] = '{0, 0};
  int          mcout [2] = '{0, 0};
  int          mmax [2] = '{0, 0};

  always @(posedge clk or posedge rst) begin
    logic        take;
    logic [31:0] front;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mcnt[i] = 0; mreq[i] = 1'b0; mack[i] = 1'b0; mdout[i] = '0;
        movf[i] = 1'b0; mcin[i] = 0; mcout[i] = 0; mmax[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        take  = in_reqr[i] && !mack[i] && (mcnt[i] > 0);
        front = mq[i][0];
        if (take) begin
          for (int j = 0; j < 7; j++) mq[i][j] = mq[i][j+1];
          mcnt[i]--;
          mcout[i]++;
        end
        if (in_ackl[i]) begin
          if (mcnt[i] < dep[i]) begin
            mq[i][mcnt[i]] = in_din[i];
            mcnt[i]++;
            mcin[i]++;
          end else begin
            movf[i] = 1'b1;
          end
        end
        mreq[i] = (mcnt[i] < dep[i]);
        mack[i] = take;
        if (take) mdout[i] = front;
        if (mcnt[i] > mmax[i]) mmax[i] = mcnt[i];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        string p;
        p = (i == 0) ? "a" : "b";
        chk({p, "_req_l"},    32'(o_reql[i]), 32'(mreq[i]));
        chk({p, "_ack_r"},    32'(o_ack[i]),  32'(mack[i]));
        chk({p, "_dout"},     o_dout[i],      mdout[i]);
        chk({p, "_level"},    32'(o_lvl[i]),  32'(mcnt[i]));
        chk({p, "_overflow"}, 32'(o_ovf[i]),  32'(movf[i]));
      end
`ifdef HS_FIFO_STATS_EN
      chk("a_cnt_in",    a_cnt_in,           32'(mcin[0]));
      chk("a_cnt_out",   a_cnt_out,          32'(mcout[0]));
      chk("a_max_level", 32'(a_max_level),   32'(mmax[0]));
      chk("b_cnt_in",    b_cnt_in,           32'(mcin[1]));
      chk("b_cnt_out",   b_cnt_out,          32'(mcout[1]));
      chk("b_max_level", 32'(b_max_level),   32'(mmax[1]));
`endif
    end
  end

  typedef struct {
    logic        ack;
    logic [31:0] din;
    logic        req;
    logic        e_reql;
    logic        e_ack;
    logic [31:0] e_dout;
    int          e_lvl;
    logic        e_ovf;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mkv(input logic ack, input logic [31:0] din, input logic req,
                               input logic ereq, input logic eack, input logic [31:0] edout,
                               input int elvl, input logic eovf);
    vec_t v;
    v.ack = ack; v.din = din; v.req = req;
    v.e_reql = ereq; v.e_ack = eack; v.e_dout = edout; v.e_lvl = elvl; v.e_ovf = eovf;
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_req_l"},  32'(a_req_l), 0);
    chk({tag, "_a_ack_r"},  32'(a_ack_r), 0);
    chk({tag, "_a_dout"},   a_dout, 0);
    chk({tag, "_a_level"},  32'(a_level), 0);
    chk({tag, "_a_ovf"},    32'(a_overflow), 0);
    chk({tag, "_b_ack_r"},  32'(b_ack_r), 0);
    chk({tag, "_b_level"},  32'(b_level), 0);
`ifdef HS_FIFO_STATS_EN
    chk({tag, "_a_cnt_in"},  a_cnt_in, 0);
    chk({tag, "_a_cnt_out"}, a_cnt_out, 0);
    chk({tag, "_a_max"},     32'(a_max_level), 0);
`endif
  endtask

  // Producer acks only while it sees req_l and never twice in a row.
  task automatic run_stream(input int sel, input int n, input int pf, input int cf,
                            input int budget);
    int sent = 0, got = 0, cyc = 0, last = 0;
    logic rack, rreq, cur_ack, nack;
    logic [31:0] rdout;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (sel == 0) begin rack = a_ack_r; rdout = a_dout; rreq = a_req_l; cur_ack = a_ack_l; end
      else          begin rack = b_ack_r; rdout = b_dout; rreq = b_req_l; cur_ack = b_ack_l; end
      if (rack) begin
        chk("stream_data", rdout, 32'(got));
        if (pf == 0 && cf == 0 && got > 0) chk("ack_spacing", 32'(cyc - last), 2);
        last = cyc;
        got++;
      end
      nack = rreq && !cur_ack && (sent < n) && ($urandom_range(99) >= 32'(pf));
      if (sel == 0) begin
        a_ack_l = nack; a_din = 32'(sent); a_req_r = ($urandom_range(99) >= 32'(cf));
      end else begin
        b_ack_l = nack; b_din = 32'(sent); b_req_r = ($urandom_range(99) >= 32'(cf));
      end
      if (nack) sent++;
    end
    chk("stream_done", 32'(got), 32'(n));
    a_ack_l = 1'b0; a_req_r = 1'b0; b_ack_l = 1'b0; b_req_r = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b0;
    a_ack_l = 1'b0; a_din = '0; a_req_r = 1'b0;
    b_ack_l = 1'b0; b_din = '0; b_req_r = 1'b0;

    // fill 0..3, simultaneous read+write at full, overflow, then drain
    tbl[0]  = mkv(0, 32'h0,    0, 1, 0, 32'h0, 0, 0);
    tbl[1]  = mkv(1, 32'h0,    0, 1, 0, 32'h0, 1, 0);
    tbl[2]  = mkv(0, 32'h0,    0, 1, 0, 32'h0, 1, 0);
    tbl[3]  = mkv(1, 32'h1,    0, 1, 0, 32'h0, 2, 0);
    tbl[4]  = mkv(0, 32'h0,    0, 1, 0, 32'h0, 2, 0);
    tbl[5]  = mkv(1, 32'h2,    0, 1, 0, 32'h0, 3, 0);
    tbl[6]  = mkv(0, 32'h0,    0, 1, 0, 32'h0, 3, 0);
    tbl[7]  = mkv(1, 32'h3,    0, 0, 0, 32'h0, 4, 0);
    tbl[8]  = mkv(0, 32'h0,    0, 0, 0, 32'h0, 4, 0);
    tbl[9]  = mkv(1, 32'h4,    1, 0, 1, 32'h0, 4, 0);
    tbl[10] = mkv(0, 32'h0,    0, 0, 0, 32'h0, 4, 0);
    tbl[11] = mkv(1, 32'hDEAD, 0, 0, 0, 32'h0, 4, 1);
    tbl[12] = mkv(0, 32'h0,    0, 0, 0, 32'h0, 4, 1);
    tbl[13] = mkv(0, 32'h0,    1, 1, 1, 32'h1, 3, 1);
    tbl[14] = mkv(0, 32'h0,    1, 1, 0, 32'h1, 3, 1);
    tbl[15] = mkv(0, 32'h0,    1, 1, 1, 32'h2, 2, 1);
    tbl[16] = mkv(0, 32'h0,    1, 1, 0, 32'h2, 2, 1);
    tbl[17] = mkv(0, 32'h0,    1, 1, 1, 32'h3, 1, 1);
    tbl[18] = mkv(0, 32'h0,    1, 1, 0, 32'h3, 1, 1);
    tbl[19] = mkv(0, 32'h0,    1, 1, 1, 32'h4, 0, 1);
    tbl[20] = mkv(0, 32'h0,    1, 1, 0, 32'h4, 0, 1);

    // asynchronous reset mid-cycle
    @(negedge clk); #2 rst = 1'b1; #1;
    chk_all_zero("reset");
    @(negedge clk); rst = 1'b0; chk_en = 1'b1;

    for (int k = 0; k < 21; k++) begin
      a_ack_l = tbl[k].ack; a_din = tbl[k].din; a_req_r = tbl[k].req;
      @(negedge clk);
      chk($sformatf("tbl%0d_req_l", k),    32'(a_req_l),    32'(tbl[k].e_reql));
      chk($sformatf("tbl%0d_ack_r", k),    32'(a_ack_r),    32'(tbl[k].e_ack));
      chk($sformatf("tbl%0d_dout", k),     a_dout,          tbl[k].e_dout);
      chk($sformatf("tbl%0d_level", k),    32'(a_level),    32'(tbl[k].e_lvl));
      chk($sformatf("tbl%0d_overflow", k), 32'(a_overflow), 32'(tbl[k].e_ovf));
    end
    a_ack_l = 1'b0; a_req_r = 1'b0;

    // clear overflow, then full-rate streaming on depth 4
    #2 rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    run_stream(0, 5000, 0, 0, 12000);
    chk("stream_overflow", 32'(a_overflow), 0);

    // reset with two words buffered
    @(negedge clk); a_ack_l = 1'b1; a_din = 32'h100;
    @(negedge clk); a_ack_l = 1'b0;
    @(negedge clk); a_ack_l = 1'b1; a_din = 32'h101;
    @(negedge clk); a_ack_l = 1'b0;
    chk("midrst_level_before", 32'(a_level), 2);
    #2 rst = 1'b1; #1;
    chk_all_zero("midrst");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    a_ack_l = 1'b1; a_din = 32'h55; a_req_r = 1'b1;
    @(negedge clk); a_ack_l = 1'b0;
    seen = 0;
    for (int c = 0; c < 8 && seen == 0; c++) begin
      if (a_ack_r) begin
        seen = 1;
        chk("midrst_first_word", a_dout, 32'h55);
      end else begin
        @(negedge clk);
      end
    end
    chk("midrst_ack_seen", 32'(seen), 1);
    a_req_r = 1'b0;
    repeat (2) @(negedge clk);

    // random stalls and pointer wrap on depth 3
    run_stream(1, 2000, 40, 40, 40000);
    chk("wrap_overflow", 32'(b_overflow), 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
